// File: rtl/code_prefetch.sv
// Instruction prefetch queue: keeps a dword FIFO of code ahead of the decoder and
// presents the oldest four dwords plus the byte offset of the current instruction.
module code_prefetch #(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] RESET_ADDR = 32'h000FFFF0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic [31:0]  flush_addr,
  input  logic         consume,
  input  logic [3:0]   consume_len,
  output logic [127:0] codebuf,
  output logic [1:0]   align,
  output logic         code_valid,
  output logic [31:0]  mem_address,
  output logic         mem_read,
  input  logic         mem_ready,
  input  logic [31:0]  mem_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [31:0]      queue_reg [DEPTH];
  logic [PTR_W-1:0] head_reg, head_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [1:0]       align_reg, align_next;
  logic [31:0]      fetch_ptr_reg, fetch_ptr_next;
  logic [31:0]      mem_address_reg, mem_address_next;
  logic             mem_read_reg, mem_read_next;
  logic             discard_reg, discard_next;

  logic             take, capture, outstanding, blocked, consume_ok;
  logic [4:0]       sum;
  logic [2:0]       drop;
  logic [PTR_W-1:0] tail;

  assign code_valid  = (count_reg >= CNT_W'(4));
  assign align       = align_reg;
  assign mem_read    = mem_read_reg;
  assign mem_address = mem_address_reg;

  // Window onto the four oldest entries, read straight from registered state.
  for (genvar gi = 0; gi < 4; gi++) begin : g_window
    assign codebuf[32*gi +: 32] = queue_reg[head_reg + PTR_W'(gi)];
  end

  assign sum  = {3'b000, align_reg} + {1'b0, consume_len};
  assign drop = sum[4:2];
  // head+count is invariant under a drop, so the post-drop tail equals the current one.
  assign tail = head_reg + count_reg[PTR_W-1:0];

  always_comb begin
    head_next        = head_reg;
    count_next       = count_reg;
    align_next       = align_reg;
    fetch_ptr_next   = fetch_ptr_reg;
    mem_address_next = mem_address_reg;
    mem_read_next    = mem_read_reg;
    discard_next     = discard_reg;

    take        = mem_read_reg && mem_ready;
    capture     = take && !discard_reg && !flush;
    consume_ok  = !flush && consume && code_valid && (consume_len != 4'd0);
    outstanding = mem_read_reg && !mem_ready;
    // A stale word completing this cycle still blocks issue unless a flush overrides it.
    blocked     = discard_reg && !flush;

    if (flush) begin
      count_next     = '0;
      align_next     = flush_addr[1:0];
      fetch_ptr_next = {flush_addr[31:2], 2'b00};
      discard_next   = outstanding;
    end else begin
      if (consume_ok) begin
        head_next  = head_reg + PTR_W'(drop);
        count_next = count_reg - CNT_W'(drop);
        align_next = sum[1:0];
      end
      if (capture) begin
        count_next     = count_next + CNT_W'(1);
        fetch_ptr_next = fetch_ptr_reg + 32'd4;
      end
      if (take && discard_reg) begin
        discard_next = 1'b0;
      end
    end

    if (!outstanding) begin
      if (!blocked && (count_next < FULL)) begin
        mem_read_next    = 1'b1;
        mem_address_next = fetch_ptr_next;
      end else begin
        mem_read_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_reg        <= '0;
      count_reg       <= '0;
      align_reg       <= RESET_ADDR[1:0];
      fetch_ptr_reg   <= {RESET_ADDR[31:2], 2'b00};
      mem_address_reg <= {RESET_ADDR[31:2], 2'b00};
      mem_read_reg    <= 1'b0;
      discard_reg     <= 1'b0;
    end else begin
      head_reg        <= head_next;
      count_reg       <= count_next;
      align_reg       <= align_next;
      fetch_ptr_reg   <= fetch_ptr_next;
      mem_address_reg <= mem_address_next;
      mem_read_reg    <= mem_read_next;
      discard_reg     <= discard_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        queue_reg[i] <= '0;
      end
    end else if (capture) begin
      queue_reg[tail] <= mem_data;
    end
  end

endmodule

// File: tb/tb_code_prefetch.sv
// Bench for code_prefetch: a behavioural memory plus a queue scoreboard of the words
// the prefetcher should hold, checked after every clock edge.
module tb_code_prefetch;

  logic         clock = 1'b0;
  logic         reset, flush, consume, mem_ready;
  logic [31:0]  flush_addr, mem_data;
  logic [3:0]   consume_len;
  logic [127:0] codebuf;
  logic [1:0]   align;
  logic         code_valid, mem_read;
  logic [31:0]  mem_address;

  code_prefetch #(.DEPTH(8), .RESET_ADDR(32'h000FFFF0)) dut (
    .clock(clock), .reset(reset), .flush(flush), .flush_addr(flush_addr),
    .consume(consume), .consume_len(consume_len), .codebuf(codebuf), .align(align),
    .code_valid(code_valid), .mem_address(mem_address), .mem_read(mem_read),
    .mem_ready(mem_ready), .mem_data(mem_data)
  );

  always #5 clock = ~clock;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  exp_align;
  logic [31:0] exp_next;
  bit          exp_disc;
  bit          mem_en;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_align = 2'd0;
    exp_next  = 32'h000FFFF0;
    exp_disc  = 1'b0;
  endtask

  // Memory side: answer the current request, and check its address against the stream.
  task automatic respond();
    if (mem_read === 1'b1) begin
      if (!exp_disc) begin
        vectors++;
        if (mem_address !== exp_next) begin
          $display("FAIL fetch_addr: got %h want %h", mem_address, exp_next);
          miscompares++;
        end
      end
      mem_ready = mem_en;
      mem_data  = mem_en ? mem_fn(mem_address) : 32'h0;
    end else begin
      mem_ready = 1'b0;
      mem_data  = 32'h0;
    end
  endtask

  task automatic cycle();
    logic [4:0] s;
    bit ev;
    if (flush) begin
      exp_q.delete();
      exp_align = flush_addr[1:0];
      exp_next  = {flush_addr[31:2], 2'b00};
      exp_disc  = (mem_read === 1'b1) && !mem_ready;
    end else begin
      if (consume && consume_len != 4'd0 && exp_q.size() >= 4) begin
        s = {3'b000, exp_align} + {1'b0, consume_len};
        repeat (int'(s[4:2])) void'(exp_q.pop_front());
        exp_align = s[1:0];
      end
      if (mem_read === 1'b1 && mem_ready) begin
        if (exp_disc) begin
          exp_disc = 1'b0;
        end else begin
          exp_q.push_back(mem_fn(exp_next));
          $display("capture addr=%h data=%h", exp_next, mem_fn(exp_next));
          exp_next += 32'd4;
        end
      end
    end
    @(posedge clock);
    #1;
    respond();
    ev = (exp_q.size() >= 4);
    vectors++;
    if (code_valid !== ev) begin
      $display("FAIL code_valid: got %b want %b", code_valid, ev);
      miscompares++;
    end
    vectors++;
    if (align !== exp_align) begin
      $display("FAIL align: got %0d want %0d", align, exp_align);
      miscompares++;
    end
    if (ev) begin
      vectors++;
      if (codebuf !== {exp_q[3], exp_q[2], exp_q[1], exp_q[0]}) begin
        $display("FAIL codebuf: got %h want %h", codebuf, {exp_q[3], exp_q[2], exp_q[1], exp_q[0]});
        miscompares++;
      end
    end
  endtask

  task automatic do_consume(input logic [3:0] len);
    $display("consume len=%0d", len);
    consume = 1'b1;
    consume_len = len;
    cycle();
    consume = 1'b0;
    consume_len = 4'd0;
  endtask

  task automatic do_flush(input logic [31:0] a);
    $display("flush addr=%h", a);
    flush = 1'b1;
    flush_addr = a;
    cycle();
    flush = 1'b0;
  endtask

  task automatic wait_size(input int n);
    for (int i = 0; i < 200 && exp_q.size() < n; i++) cycle();
    vectors++;
    if (exp_q.size() < n) begin
      $display("FAIL wait_size: got %0d words want %0d (timeout)", exp_q.size(), n);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; consume = 1'b0; consume_len = 4'd0;
    flush_addr = 32'h0; mem_ready = 1'b0; mem_data = 32'h0; mem_en = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if (mem_read !== 1'b0 || code_valid !== 1'b0 || align !== 2'd0 || codebuf !== 128'h0) begin
      $display("FAIL reset_state: got rd=%b v=%b al=%0d buf=%h want 0/0/0/0", mem_read, code_valid, align, codebuf);
      miscompares++;
    end
    reset = 1'b0;
    respond();
  endtask

  task automatic test_fill();
    cycle();
    vectors++;
    if (mem_read !== 1'b1 || mem_address !== 32'h000FFFF0) begin
      $display("FAIL first_read: got rd=%b addr=%h want 1 000ffff0", mem_read, mem_address);
      miscompares++;
    end
    cycle();
    cycle();
    do_consume(4'd3);  // ignored: fewer than four dwords held
    wait_size(4);
    vectors++;
    if (code_valid !== 1'b1 || codebuf !== {mem_fn(32'h000FFFFC), mem_fn(32'h000FFFF8),
                                            mem_fn(32'h000FFFF4), mem_fn(32'h000FFFF0)}) begin
      $display("FAIL fill_window: got v=%b buf=%h", code_valid, codebuf);
      miscompares++;
    end
  endtask

  task automatic test_full();
    wait_size(8);
    cycle();
    vectors++;
    if (mem_read !== 1'b0) begin
      $display("FAIL full_no_issue: got mem_read=%b want 0", mem_read);
      miscompares++;
    end
    do_consume(4'd5);
    vectors++;
    if (align !== 2'd1 || mem_read !== 1'b1 || mem_address !== 32'h00100010) begin
      $display("FAIL consume5: got al=%0d rd=%b addr=%h want 1 1 00100010", align, mem_read, mem_address);
      miscompares++;
    end
    cycle();
    do_consume(4'd2);
    do_consume(4'd0);
    do_consume(4'd15);
    vectors++;
    if (align !== 2'd2) begin
      $display("FAIL consume15: got align=%0d want 2", align);
      miscompares++;
    end
  endtask

  task automatic test_flush_idle();
    wait_size(8);
    cycle();
    vectors++;
    if (mem_read !== 1'b0) begin
      $display("FAIL idle_before_flush: got mem_read=%b want 0", mem_read);
      miscompares++;
    end
    do_flush(32'h00001236);
    vectors++;
    if (mem_read !== 1'b1 || mem_address !== 32'h00001234 || code_valid !== 1'b0) begin
      $display("FAIL flush_idle: got rd=%b addr=%h v=%b want 1 00001234 0", mem_read, mem_address, code_valid);
      miscompares++;
    end
    wait_size(4);
    vectors++;
    if (align !== 2'd2 || code_valid !== 1'b1) begin
      $display("FAIL flush_idle_fill: got al=%0d v=%b want 2 1", align, code_valid);
      miscompares++;
    end
  endtask

  task automatic test_flush_stall();
    wait_size(8);
    mem_en = 1'b0;
    cycle();
    do_flush(32'h00000100);
    cycle();
    do_flush(32'h00002000);
    for (int i = 0; i < 2; i++) begin
      cycle();
      vectors++;
      if (mem_read !== 1'b1 || mem_address !== 32'h00000100) begin
        $display("FAIL stall_hold: got rd=%b addr=%h want 1 00000100", mem_read, mem_address);
        miscompares++;
      end
    end
    mem_en = 1'b1;
    respond();
    cycle();
    for (int i = 0; i < 4 && mem_read !== 1'b1; i++) cycle();
    vectors++;
    if (mem_read !== 1'b1 || mem_address !== 32'h00002000) begin
      $display("FAIL post_discard_read: got rd=%b addr=%h want 1 00002000", mem_read, mem_address);
      miscompares++;
    end
    wait_size(4);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (codebuf[32*i +: 32] === 32'hDEADBEEF) begin
        $display("FAIL discarded_word: got %h in dword %0d want none", codebuf[32*i +: 32], i);
        miscompares++;
      end
    end
  endtask

  task automatic test_back_to_back();
    do_flush(32'h00003000);
    vectors++;
    if (mem_read !== 1'b1 || mem_address !== 32'h00003000) begin
      $display("FAIL flush_on_ready: got rd=%b addr=%h want 1 00003000", mem_read, mem_address);
      miscompares++;
    end
    wait_size(4);
    vectors++;
    if (mem_read !== 1'b1 || mem_ready !== 1'b1) begin
      $display("FAIL b2b_setup: got rd=%b ready=%b want 1 1", mem_read, mem_ready);
      miscompares++;
    end
    do_consume(4'd4);
    vectors++;
    if (code_valid !== 1'b1 || codebuf[127:96] !== mem_fn(32'h00003010)) begin
      $display("FAIL capture_consume: got v=%b top=%h want 1 %h", code_valid, codebuf[127:96], mem_fn(32'h00003010));
      miscompares++;
    end
  endtask

  task automatic test_wrap_and_reset();
    do_flush(32'hFFFFFFF8);
    wait_size(2);
    vectors++;
    if (mem_read !== 1'b1 || mem_address !== 32'h00000000) begin
      $display("FAIL wrap_addr: got rd=%b addr=%h want 1 00000000", mem_read, mem_address);
      miscompares++;
    end
    wait_size(5);
    vectors++;
    if (mem_read !== 1'b1 || code_valid !== 1'b1) begin
      $display("FAIL pre_reset: got rd=%b v=%b want 1 1", mem_read, code_valid);
      miscompares++;
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (mem_read !== 1'b0 || code_valid !== 1'b0 || codebuf !== 128'h0) begin
      $display("FAIL async_reset: got rd=%b v=%b buf=%h want 0 0 0", mem_read, code_valid, codebuf);
      miscompares++;
    end
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    respond();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fill();
    test_full();
    test_flush_idle();
    test_flush_stall();
    test_back_to_back();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/code_prefetch.md
Name: code_prefetch

Overview:
- Instruction prefetch queue that fills the 128-bit code window consumed by the decoder (i_codebuf + align).
- Fetches dword-aligned code from the memory bus into a dword FIFO and presents the oldest four dwords plus the byte offset of the current instruction within dword 0.
- Advances by the instruction length the decoder reports; restarts on flush (jump, interrupt, segment reload).

Parameters:
- DEPTH, 8, queue capacity in dwords (power of two, >= 5).
- RESET_ADDR, 32'h000FFFF0, linear fetch address after reset.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  discard queue, restart fetch at flush_addr
- flush_addr  in  32  linear address of next instruction
- consume  in  1  decoder retired bytes this cycle
- consume_len  in  4  bytes retired, 1..15
- codebuf  out  128  dwords 0..3 of queue, dword 0 in [31:0]
- align  out  2  byte offset of instruction start within dword 0
- code_valid  out  1  codebuf holds >= 4 valid dwords
- mem_address  out  32  dword-aligned fetch address, [1:0] = 0
- mem_read  out  1  read request
- mem_ready  in  1  read completes this cycle
- mem_data  in  32  read data, sampled when mem_read && mem_ready

Behaviour:
- Reset: queue empty (count=0), codebuf=0, code_valid=0, mem_read=0, fetch pointer = RESET_ADDR & ~3, align = RESET_ADDR[1:0], discard flag=0.
- codebuf, align and code_valid are decoded from registered state only; no combinational input-to-output path.
- code_valid = (count >= 4). Words beyond count in codebuf are don't-care.
- Bus protocol: at most one read outstanding.
  - While mem_read=1, mem_address is held stable until mem_ready.
  - Data is captured on the cycle mem_read && mem_ready.
  - mem_read deasserts the next cycle unless a further read is issued back-to-back.
- Issue rule: a read is issued (mem_read=1 on the next cycle) when no read is outstanding, no discard is pending, and count + 1 <= DEPTH after this cycle's consume.
  - On capture, the word goes to the queue tail at index count and the fetch pointer advances by 4.
  - Back-to-back: capture at cycle t, with room, gives a new address at t+1 with mem_read held high.
- Consume: honoured only when code_valid=1 (ignored otherwise, no state change).
  - Compute s = align + consume_len (0..18).
  - Drop s>>2 dwords (0..4) from the head; new align = s[1:0].
  - consume_len = 0 is a no-op.
- Simultaneous capture and consume in the same cycle:
  - The head drops first, then the new word is written at the post-drop tail.
  - count' = count - (s>>2) + 1.
- Flush has priority over consume and capture.
  - Effects: count=0, align = flush_addr[1:0], fetch pointer = flush_addr & ~3, code_valid=0 next cycle.
  - Flush while a read is outstanding and mem_ready=0: mem_read and mem_address stay held, and the discard flag is set. The returning word is dropped and the flag cleared. The first new-stream read issues the cycle after that completion.
  - Flush in the same cycle as mem_ready: the word is dropped, no discard flag is set, and the new read issues on the next cycle.
  - Flush while idle: mem_read=1 at flush_addr & ~3 on the next cycle.
  - Repeated flush while discard is pending: the latest flush_addr wins.
- Full: count = DEPTH suppresses issue. A read issued at count = DEPTH-1 is always accepted.
- Wrap-around: the fetch pointer wraps 32'hFFFFFFFC -> 0. The queue uses circular head/tail indices modulo DEPTH.
- Reset mid-read: mem_read drops immediately (asynchronous), and all state returns to reset values.

Test Plan:
- Reset then a memory returning 1 word/cycle (mem_ready=1): mem_read rises cycle 1 at 0x000FFFF0, then addresses 0x000FFFF4/F8/FC. code_valid=1 one cycle after the 4th capture. codebuf = {w3,w2,w1,w0}, align=0.
- Queue full, then consume 5 bytes at align=0: drops 1 dword, align=1. The next read issues the following cycle. Then consume_len=15 at align=3 (s=18): drops 4 dwords, align=2.
- Flush to 0x00001236 while idle: next cycle mem_read=1, mem_address=0x00001234. After 4 words, align=2, code_valid=1.
- Flush while a read to 0x00000100 stalls 3 cycles (mem_ready=0): the address is held, and data 0xDEADBEEF is discarded. The next read goes to the flush target, and the queue never contains 0xDEADBEEF.
- Simultaneous capture and consume of 4 bytes at count=4, align=0: count stays 4, and the new word appears in codebuf[127:96].
- Fetch pointer at 0xFFFFFFFC: the capture advances the pointer to 0x00000000. Asserting reset while mem_read=1 clears mem_read and code_valid asynchronously.
